// File: rtl/elevator_pkg.sv
// Shared types and floor helpers for the elevator scheduler and its display controller.
// Pure declarations: no logic, no latency, no flow control.
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        MOVING_UP   = 2'b01,
        MOVING_DOWN = 2'b10,
        DOOR_OPEN   = 2'b11
    } state_t;

    // Bits strictly above floor f.
    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        return {{(NUM_FLOORS-1){1'b1}}, 1'b0} << f;
    endfunction

    // Bits strictly below floor f.
    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        return ~({NUM_FLOORS{1'b1}} << f);
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick-enabled counter: done pulses on the tick that brings the count to limit, then wraps to 0.
// done is combinational from tick/clear; clear has priority and suppresses done.
module tick_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 hit;

    assign hit  = (cnt + ONE) >= limit;
    assign done = tick && hit && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= hit ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-ordered 8-floor elevator scheduler; req reaches destination two clk edges later, all outputs registered.
// No backpressure: calls are latched every clk and held until served at an open door.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 16,
    parameter int DOOR_TICKS   = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [1:0]            sim_state,
    output logic [NUM_FLOORS-1:0] destination,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open
);

    localparam logic [CNT_WIDTH-1:0] TRAVEL_LIM = CNT_WIDTH'(TRAVEL_TICKS);
    localparam logic [CNT_WIDTH-1:0] DOOR_LIM   = CNT_WIDTH'(DOOR_TICKS);
    localparam logic [FLOOR_W-1:0]   TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]   FLOOR_ONE  = FLOOR_W'(1);

    state_t                  state, state_nxt;
    logic [FLOOR_W-1:0]      floor_nxt;
    logic                    dir_up, dir_nxt;
    logic [NUM_FLOORS-1:0]   pend, clr;
    logic                    above, below, here;
    logic                    timer_clear, timer_done;
    logic [CNT_WIDTH-1:0]    timer_limit;

    assign above = |(pend & above_mask(current_floor));
    assign below = |(pend & below_mask(current_floor));
    assign here  = pend[current_floor];

    tick_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .clear (timer_clear),
        .limit (timer_limit),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            current_floor <= '0;
            dir_up        <= 1'b1;
            pend          <= '0;
            destination   <= '0;
        end else begin
            state         <= state_nxt;
            current_floor <= floor_nxt;
            dir_up        <= dir_nxt;
            pend          <= (pend | req) & ~clr;
            destination   <= pend;
        end
    end

    always_comb begin
        state_nxt = state;
        floor_nxt = current_floor;
        dir_nxt   = dir_up;
        case (state)
            IDLE: begin
                if (here) begin
                    state_nxt = DOOR_OPEN;
                end else if (above) begin
                    state_nxt = MOVING_UP;
                    dir_nxt   = 1'b1;
                end else if (below) begin
                    state_nxt = MOVING_DOWN;
                    dir_nxt   = 1'b0;
                end
            end
            MOVING_UP: begin
                if (timer_done && current_floor != TOP_FLOOR) begin
                    floor_nxt = current_floor + FLOOR_ONE;
                    if (pend[floor_nxt]) state_nxt = DOOR_OPEN;
                end
            end
            MOVING_DOWN: begin
                if (timer_done && current_floor != '0) begin
                    floor_nxt = current_floor - FLOOR_ONE;
                    if (pend[floor_nxt]) state_nxt = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                if (timer_done) begin
                    // Keep the current sweep direction while it still has work.
                    if (dir_up && above) begin
                        state_nxt = MOVING_UP;
                    end else if (!dir_up && below) begin
                        state_nxt = MOVING_DOWN;
                    end else if (above) begin
                        state_nxt = MOVING_UP;
                        dir_nxt   = 1'b1;
                    end else if (below) begin
                        state_nxt = MOVING_DOWN;
                        dir_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sim_state   = state;
        door_open   = (state == DOOR_OPEN);
        clr         = (state == DOOR_OPEN) ? floor_onehot(current_floor) : '0;
        // A repeat call at the open floor holds the door.
        timer_clear = (state == IDLE) || ((state == DOOR_OPEN) && req[current_floor]);
        timer_limit = (state == DOOR_OPEN) ? DOOR_LIM : TRAVEL_LIM;
    end

    a_no_overrun_top: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == MOVING_UP && current_floor == TOP_FLOOR));
    a_no_overrun_bottom: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == MOVING_DOWN && current_floor == '0));

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with TRAVEL_TICKS=4, DOOR_TICKS=2.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] req = 8'h00;
    logic [1:0] sim_state;
    logic [7:0] destination;
    logic [2:0] current_floor;
    logic       door_open;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .TRAVEL_TICKS (4),
        .DOOR_TICKS   (2),
        .CNT_WIDTH    (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .req           (req),
        .sim_state     (sim_state),
        .destination   (destination),
        .current_floor (current_floor),
        .door_open     (door_open)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic pulse(input logic [7:0] r);
        req = r;
        step();
        req = 8'h00;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++; if (sim_state !== 2'b00) begin bad++; $display("FAIL rst_state got=%b exp=00", sim_state); end
        total++; if (destination !== 8'h00) begin bad++; $display("FAIL rst_dest got=%h exp=00", destination); end
        total++; if (current_floor !== 3'd0) begin bad++; $display("FAIL rst_floor got=%0d exp=0", current_floor); end
        total++; if (door_open !== 1'b0) begin bad++; $display("FAIL rst_door got=%b exp=0", door_open); end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick_once();
            total++; if (sim_state !== 2'b00 || destination !== 8'h00 || current_floor !== 3'd0) begin
                bad++; $display("FAIL idle_hold tick=%0d got state=%b dest=%h floor=%0d exp 00/00/0", i, sim_state, destination, current_floor);
            end
        end
    endtask

    task automatic test_single_call();
        pulse(8'h08);
        step();
        total++; if (sim_state !== 2'b01) begin bad++; $display("FAIL single_start got=%b exp=01", sim_state); end
        total++; if (destination !== 8'h08) begin bad++; $display("FAIL single_dest got=%h exp=08", destination); end
        ticks(11);
        total++; if (sim_state !== 2'b01 || current_floor !== 3'd2) begin bad++; $display("FAIL single_t11 got state=%b floor=%0d exp 01/2", sim_state, current_floor); end
        tick_once();
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd3 || door_open !== 1'b1) begin bad++; $display("FAIL single_arrive got state=%b floor=%0d door=%b exp 11/3/1", sim_state, current_floor, door_open); end
        step();
        total++; if (destination !== 8'h00) begin bad++; $display("FAIL single_dest_clr got=%h exp=00", destination); end
        tick_once();
        total++; if (sim_state !== 2'b11) begin bad++; $display("FAIL single_dwell1 got=%b exp=11", sim_state); end
        tick_once();
        total++; if (sim_state !== 2'b00 || door_open !== 1'b0) begin bad++; $display("FAIL single_idle got state=%b door=%b exp 00/0", sim_state, door_open); end
    endtask

    task automatic test_scan_reverse();
        pulse(8'h41);
        step();
        total++; if (sim_state !== 2'b01) begin bad++; $display("FAIL scan_up got=%b exp=01", sim_state); end
        ticks(12);
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd6) begin bad++; $display("FAIL scan_f6 got state=%b floor=%0d exp 11/6", sim_state, current_floor); end
        step();
        total++; if (destination !== 8'h01) begin bad++; $display("FAIL scan_dest6 got=%h exp=01", destination); end
        ticks(2);
        total++; if (sim_state !== 2'b10) begin bad++; $display("FAIL scan_down got=%b exp=10", sim_state); end
        ticks(24);
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd0) begin bad++; $display("FAIL scan_f0 got state=%b floor=%0d exp 11/0", sim_state, current_floor); end
        ticks(2);
        total++; if (sim_state !== 2'b00 || destination !== 8'h00) begin bad++; $display("FAIL scan_idle got state=%b dest=%h exp 00/00", sim_state, destination); end
    endtask

    task automatic test_door_restart();
        pulse(8'h04);
        step();
        ticks(8);
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd2) begin bad++; $display("FAIL door_arrive got state=%b floor=%0d exp 11/2", sim_state, current_floor); end
        tick_once();
        total++; if (sim_state !== 2'b11) begin bad++; $display("FAIL door_t1 got=%b exp=11", sim_state); end
        pulse(8'h04);
        step();
        total++; if (destination[2] !== 1'b0) begin bad++; $display("FAIL door_absorb got=%b exp=0", destination[2]); end
        tick_once();
        total++; if (sim_state !== 2'b11) begin bad++; $display("FAIL door_restart got=%b exp=11", sim_state); end
        tick_once();
        total++; if (sim_state !== 2'b00 || destination !== 8'h00) begin bad++; $display("FAIL door_close got state=%b dest=%h exp 00/00", sim_state, destination); end
    endtask

    task automatic test_scan_multi();
        pulse(8'h80);
        step();
        total++; if (sim_state !== 2'b01) begin bad++; $display("FAIL multi_up got=%b exp=01", sim_state); end
        pulse(8'hAA);
        step();
        total++; if (destination !== 8'hAA) begin bad++; $display("FAIL multi_dest got=%h exp=aa", destination); end
        ticks(4);
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd3) begin bad++; $display("FAIL multi_f3 got state=%b floor=%0d exp 11/3", sim_state, current_floor); end
        step();
        total++; if (destination !== 8'hA2) begin bad++; $display("FAIL multi_dest3 got=%h exp=a2", destination); end
        ticks(2);
        total++; if (sim_state !== 2'b01) begin bad++; $display("FAIL multi_leave3 got=%b exp=01", sim_state); end
        ticks(8);
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd5) begin bad++; $display("FAIL multi_f5 got state=%b floor=%0d exp 11/5", sim_state, current_floor); end
        step();
        total++; if (destination !== 8'h82) begin bad++; $display("FAIL multi_dest5 got=%h exp=82", destination); end
        ticks(2);
        ticks(8);
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd7) begin bad++; $display("FAIL multi_f7 got state=%b floor=%0d exp 11/7", sim_state, current_floor); end
        step();
        total++; if (destination !== 8'h02) begin bad++; $display("FAIL multi_dest7 got=%h exp=02", destination); end
        ticks(2);
        total++; if (sim_state !== 2'b10) begin bad++; $display("FAIL multi_reverse got=%b exp=10", sim_state); end
        ticks(24);
        total++; if (sim_state !== 2'b11 || current_floor !== 3'd1) begin bad++; $display("FAIL multi_f1 got state=%b floor=%0d exp 11/1", sim_state, current_floor); end
        step();
        total++; if (destination !== 8'h00) begin bad++; $display("FAIL multi_dest1 got=%h exp=00", destination); end
        ticks(2);
        total++; if (sim_state !== 2'b00) begin bad++; $display("FAIL multi_idle got=%b exp=00", sim_state); end
    endtask

    task automatic test_reset_mid_travel();
        pulse(8'h80);
        step();
        ticks(12);
        tick_once();
        total++; if (sim_state !== 2'b01 || current_floor !== 3'd4) begin bad++; $display("FAIL mid_pre got state=%b floor=%0d exp 01/4", sim_state, current_floor); end
        rst_n = 1'b0;
        #1;
        total++; if (sim_state !== 2'b00) begin bad++; $display("FAIL mid_rst_state got=%b exp=00", sim_state); end
        total++; if (current_floor !== 3'd0) begin bad++; $display("FAIL mid_rst_floor got=%0d exp=0", current_floor); end
        total++; if (destination !== 8'h00 || door_open !== 1'b0) begin bad++; $display("FAIL mid_rst_dest got dest=%h door=%b exp 00/0", destination, door_open); end
        #1 rst_n = 1'b1;
        step();
        ticks(5);
        total++; if (sim_state !== 2'b00 || current_floor !== 3'd0 || destination !== 8'h00) begin
            bad++; $display("FAIL mid_pend_lost got state=%b floor=%0d dest=%h exp 00/0/00", sim_state, current_floor, destination);
        end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan_reverse();
        test_door_restart();
        test_scan_multi();
        test_reset_mid_travel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request-latching, SCAN-ordered elevator scheduler for an 8-floor car. It sits directly upstream of the VGA display controller and drives that controller's `sim_state` and `destination` inputs. It also exports the car position for the display and for debug. Time advances on a single-cycle `tick` enable, typically a divided pixel clock, so the FSM runs at a human-visible rate.

## Interface
- `TRAVEL_TICKS`, default 16: ticks needed to move one floor; legal range 1..255.
- `DOOR_TICKS`, default 8: ticks the door stays open; legal range 1..255.
- `CNT_WIDTH`, default 8: width of the tick counter; must satisfy 2^CNT_WIDTH > max(TRAVEL_TICKS, DOOR_TICKS).

- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tick`  in  1: time-base enable, one `clk` wide; all timers count only on `tick`.
- `req`  in  8: floor-call buttons, bit i = floor i; level-sensitive and sampled every `clk`.
- `sim_state`  out  2: car state encoding for the display.
  - 00 = IDLE
  - 01 = MOVING_UP
  - 10 = MOVING_DOWN
  - 11 = DOOR_OPEN
- `destination`  out  8: pending-request mask, bit i set = floor i still to be served.
- `current_floor`  out  3: car position, 0..7.
- `door_open`  out  1: high exactly when `sim_state` == DOOR_OPEN.

## Operation
- Reset values:
  - `sim_state` = 00
  - `destination` = 0
  - `current_floor` = 0
  - `door_open` = 0
  - timer = 0
  - `dir_up` = 1
- Pending register: `pend <= (pend | req) & ~clr`.
  - `clr` is the one-hot of `current_floor` while in DOOR_OPEN, and 0 otherwise.
  - If a set and a clear hit the same bit in the same cycle, the clear wins: a call at the open floor is absorbed.
  - `destination` = `pend`, registered.
- `above` = any `pend` bit strictly greater than `current_floor`; `below` = any bit strictly less; `here` = `pend[current_floor]`.
- IDLE
  - `here` → DOOR_OPEN.
  - else `above` → MOVING_UP, `dir_up` = 1.
  - else `below` → MOVING_DOWN, `dir_up` = 0.
  - else stay in IDLE.
- MOVING_UP / MOVING_DOWN
  - Timer counts on `tick`.
  - On the tick that makes the timer reach TRAVEL_TICKS: timer clears and `current_floor` moves ±1.
  - If the new floor is pending → DOOR_OPEN; otherwise stay moving.
  - Never step past floor 7 or below floor 0. Reaching an end floor with no request there is impossible by construction; assert it in simulation.
- DOOR_OPEN
  - Timer counts on `tick`.
  - A `req` bit for `current_floor` arriving during DOOR_OPEN restarts the timer to 0.
  - On expiry (timer reaches DOOR_TICKS), evaluated in this order:
    - if `dir_up` and `above` → MOVING_UP
    - else if `!dir_up` and `below` → MOVING_DOWN
    - else if `above` → MOVING_UP and set `dir_up`
    - else if `below` → MOVING_DOWN and clear `dir_up`
    - else → IDLE
- Requests for other floors are latched in every state and never dropped.
- Reset asserted mid-move or with the door open forces all reset values immediately; `pend` is lost.

## Timing
- `req` sampled on edge N appears on `destination` after edge N+1.
- IDLE → first state change is one `clk` after `pend` becomes non-zero. No tick is needed for that decision.
- Floor-to-floor travel takes exactly TRAVEL_TICKS ticks. `current_floor` and `sim_state` update on the same edge.
- Door dwell takes exactly DOOR_TICKS ticks from entry, or from the last restart.
- All outputs are registered; there are no combinational paths from `req` or `tick` to any output.

## Structure
- Shared package `elevator_pkg` holds:
  - `state_t`, a 2-bit enum carrying the encoding above; the display controller uses it too.
  - `NUM_FLOORS` = 8.
  - `FLOOR_W` = 3.
- One natural sub-module: `tick_timer`.
  - Ports: `clk`, `rst_n`, `tick`, `clear`, `limit[CNT_WIDTH-1:0]` → `done`.
  - Used once, with its limit muxed between TRAVEL_TICKS and DOOR_TICKS according to state.
- The above/below detection is a masked OR-reduce; no priority encoder is needed.

## Test plan
- Reset, then `req` = 0 for 100 ticks → `sim_state` = 00, `destination` = 0, `current_floor` = 0 throughout.
- From floor 0, pulse `req` = 8'h08 (TRAVEL_TICKS=4, DOOR_TICKS=2) → MOVING_UP for 12 ticks, then `current_floor` = 3, `sim_state` = 11, `destination` = 0; after 2 ticks → IDLE.
- Car at floor 3 moving up with pend = 8'h41 (floors 0 and 6) → serves 6 first, then reverses and serves 0; `sim_state` sequence is 01, 11, 10, 11, 00.
- Door open at floor 2; hold `req[2]` for 1 cycle at timer = 1 → timer restarts, total dwell = DOOR_TICKS+1 ticks; bit 2 never appears in `destination`.
- `req` = 8'hAA pulsed while moving → `destination` = 8'hAA next cycle; floors are served in SCAN order and the mask clears bit by bit.
- Assert `rst_n` low mid-travel at floor 4 → all outputs return to reset values asynchronously, before the next `clk` edge.
